// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MA    = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BR_EX = 4'd8,
    S_J_EX  = 4'd9,
    S_IEX   = 4'd10,
    S_IWB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU operation decode: funct table for R-type, opcode for immediates.
// Flags R-type functs the datapath cannot execute.
module alu_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      case (funct_i)
        FN_ADD:  alu_ctrl_o = ALU_ADD;
        FN_SUB:  alu_ctrl_o = ALU_SUB;
        FN_AND:  alu_ctrl_o = ALU_AND;
        FN_OR:   alu_ctrl_o = ALU_OR;
        FN_SLT:  alu_ctrl_o = ALU_SLT;
        FN_NOR:  alu_ctrl_o = ALU_NOR;
        default: illegal_o  = 1'b1;
      endcase
    end else if (opcode_i == OP_SLTI) begin
      alu_ctrl_o = ALU_SLT;
    end
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control FSM: one micro-step per clock, controls decoded from state
// (qualified by mem_ready/zero/opcode); memory states abort after MEM_TIMEOUT idle cycles.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       inst_done,
  output logic       illegal_inst,
  output logic       mem_err
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_wait;
  logic       expired;
  logic [2:0] dec_alu;
  logic       dec_illegal;

  alu_ctrl_dec u_dec (
    .opcode_i   (opcode),
    .funct_i    (funct),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );

  // A ready arriving on the counter's final value still counts as a success.
  assign expired = (cnt_q == TMO) && !mem_ready;
  assign state   = state_q;

  always_comb begin
    state_d      = state_q;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_B;
    ALU_Control  = ALU_AND;
    PCSource     = PCSRC_ALU;
    inst_done    = 1'b0;
    illegal_inst = 1'b0;
    mem_err      = 1'b0;
    mem_wait     = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead     = 1'b1;
        ALUSrcB     = SRCB_4;
        ALU_Control = ALU_ADD;
        mem_wait    = 1'b1;
        IRWrite     = mem_ready;
        PCWrite     = mem_ready;
        if (mem_ready) state_d = S_ID;
        else if (expired) mem_err = 1'b1;
      end
      S_ID: begin
        ALUSrcB     = SRCB_IMM_SH;
        ALU_Control = ALU_ADD;
        case (opcode)
          OP_RTYPE:         state_d = S_REX;
          OP_LW, OP_SW:     state_d = S_MA;
          OP_BEQ, OP_BNE:   state_d = S_BR_EX;
          OP_J:             state_d = S_J_EX;
          OP_ADDI, OP_SLTI: state_d = S_IEX;
          default: begin
            illegal_inst = 1'b1;
            inst_done    = 1'b1;
            state_d      = S_IF;
          end
        endcase
      end
      S_MA: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_Control = ALU_ADD;
        state_d     = (opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_MWB;
        else if (expired) begin
          mem_err = 1'b1;
          state_d = S_IF;
        end
      end
      S_MWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      S_MWR: begin
        IorD     = 1'b1;
        mem_wait = 1'b1;
        // The write strobe is withheld on the abort cycle so nothing commits.
        MemWrite = mem_ready || !expired;
        if (mem_ready) begin
          inst_done = 1'b1;
          state_d   = S_IF;
        end else if (expired) begin
          mem_err = 1'b1;
          state_d = S_IF;
        end
      end
      S_REX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALU_Control = dec_alu;
        if (dec_illegal) begin
          illegal_inst = 1'b1;
          inst_done    = 1'b1;
          state_d      = S_IF;
        end else begin
          state_d = S_RWB;
        end
      end
      S_RWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      S_BR_EX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALU_Control = ALU_SUB;
        PCSource    = PCSRC_ALUOUT;
        PCWrite     = (opcode == OP_BNE) ? ~zero : zero;
        inst_done   = 1'b1;
        state_d     = S_IF;
      end
      S_J_EX: begin
        PCSource  = PCSRC_JUMP;
        PCWrite   = 1'b1;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      S_IEX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_Control = dec_alu;
        state_d     = S_IWB;
      end
      S_IWB: begin
        RegWrite  = 1'b1;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Any state change (or an IF abort, which stays in IF) starts a fresh wait window.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || mem_err) cnt_d = '0;
    else if (mem_wait && !mem_ready) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench: each instruction's expected outcome is derived from the ISA-level
// rules, queued at issue time, and compared by a monitor when the FSM signals completion.
module tb_mc_ctrl_unit;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [3:0] state;
  logic       inst_done, illegal_inst, mem_err;

  always #5 clk = ~clk;

  mc_ctrl_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCSource(PCSource), .state(state),
    .inst_done(inst_done), .illegal_inst(illegal_inst), .mem_err(mem_err)
  );

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    logic       r;
  } cyc_t;

  typedef struct {
    int cycles, path, done, ill, err, rstev;
    int ir_wr, reg_wr, dst, m2r, mem_wr, mem_rd, iord, pc_wr, pcsrc, alu;
  } exp_t;

  exp_t q[$];
  cyc_t cq[$];
  int   n_cmp = 0, n_bad = 0, n_txn = 0;
  bit   mon_en = 0;

  function automatic int pth(input int p, input int s);
    return (p << 4) | (s + 1);
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s (txn %0d): got %0d, expected %0d", nm, n_txn, act, want);
    end
  endtask

  task automatic step(input int s, inout cyc_t c, inout exp_t e);
    e.path = pth(e.path, s);
    c.mr = 1'b0;
    c.r  = 1'b0;
    cq.push_back(c);
    e.cycles++;
  endtask

  // One memory access: waits w cycles then ready; a reset may cut it short.
  task automatic mem(input int s, input int w, input int rst_at, inout cyc_t c,
                     inout exp_t e, output bit ok);
    ok = 0;
    e.path = pth(e.path, s);
    for (int k = 0; k <= TMO; k++) begin
      c.r  = (k == rst_at);
      c.mr = (k == w);
      cq.push_back(c);
      e.cycles++;
      if (s != 5) e.mem_rd++;
      if (s != 0) e.iord++;
      if (c.r) begin
        e.rstev = 1;
        c.r = 1'b0;
        c.mr = 1'b0;
        return;
      end
      if (k == w) begin
        ok = 1;
        c.mr = 1'b0;
        return;
      end
    end
    e.err = 1;
    c.mr = 1'b0;
  endtask

  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wif, input int wmem, input int rst_at, output exp_t e);
    cyc_t c;
    bit   ok;
    int   a;
    e.cycles = 0; e.path = 0; e.done = 0; e.ill = 0; e.err = 0; e.rstev = 0;
    e.ir_wr = 0; e.reg_wr = 0; e.dst = -1; e.m2r = -1; e.mem_wr = 0; e.mem_rd = 0;
    e.iord = 0; e.pc_wr = 0; e.pcsrc = -1; e.alu = -1;
    c.op = op; c.fn = fn; c.z = z; c.mr = 1'b0; c.r = 1'b0;
    mem(0, wif, -1, c, e, ok);
    if (!ok) return;
    e.ir_wr = 1;
    step(1, c, e);
    case (op)
      6'b000000: begin
        step(6, c, e);
        case (fn)
          6'b100000: a = 2;
          6'b100010: a = 6;
          6'b100100: a = 0;
          6'b100101: a = 1;
          6'b101010: a = 7;
          6'b100111: a = 4;
          default:   a = -2;
        endcase
        if (a == -2) begin
          e.ill = 1; e.done = 1; e.alu = -2;
          return;
        end
        e.alu = a;
        step(7, c, e);
        e.reg_wr = 1; e.dst = 1; e.m2r = 0; e.done = 1;
      end
      6'b100011: begin
        step(2, c, e);
        e.alu = 2;
        mem(3, wmem, rst_at, c, e, ok);
        if (!ok) return;
        step(4, c, e);
        e.reg_wr = 1; e.dst = 0; e.m2r = 1; e.done = 1;
      end
      6'b101011: begin
        step(2, c, e);
        e.alu = 2;
        mem(5, wmem, -1, c, e, ok);
        e.mem_wr = ok ? wmem + 1 : TMO;
        e.done = ok;
      end
      6'b000100, 6'b000101: begin
        step(8, c, e);
        e.alu = 6;
        e.pc_wr = (op == 6'b000100) ? int'(z) : int'(!z);
        e.pcsrc = (e.pc_wr != 0) ? 1 : -1;
        e.done = 1;
      end
      6'b000010: begin
        step(9, c, e);
        e.pc_wr = 1; e.pcsrc = 2; e.done = 1;
      end
      6'b001000, 6'b001010: begin
        step(10, c, e);
        e.alu = (op == 6'b001000) ? 2 : 7;
        step(11, c, e);
        e.reg_wr = 1; e.dst = 0; e.m2r = 0; e.done = 1;
      end
      default: begin
        e.ill = 1; e.done = 1;
      end
    endcase
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int wif, input int wmem, input int rst_at);
    exp_t e;
    cyc_t c;
    model(op, fn, z, wif, wmem, rst_at, e);
    q.push_back(e);
    while (cq.size() > 0) begin
      c = cq.pop_front();
      @(negedge clk);
      opcode = c.op; funct = c.fn; zero = c.z; mem_ready = c.mr; rst = c.r;
    end
  endtask

  // Monitor: accumulates what the controls did over one instruction.
  initial begin
    exp_t e;
    int cyc = 0, path = 0, last = -1;
    int ir_wr = 0, reg_wr = 0, dst = -1, m2r = -1, mem_wr = 0, mem_rd = 0, iord = 0;
    int pc_wr = 0, pcsrc = -1, alu = -1;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (cyc == 1 || int'(state) != last) path = pth(path, int'(state));
      last = int'(state);
      if (IRWrite) ir_wr++;
      if (MemRead) mem_rd++;
      if (IorD) iord++;
      if (MemWrite) mem_wr++;
      if (RegWrite) begin reg_wr++; dst = int'(RegDst); m2r = int'(MemtoReg); end
      if (PCWrite && !IRWrite) begin pc_wr++; pcsrc = int'(PCSource); end
      if (ALUSrcA) alu = int'(ALU_Control);
      if (inst_done || mem_err || rst) begin
        if (q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e = q.pop_front();
          chk("cycles", cyc, e.cycles);
          chk("state_path", path, e.path);
          chk("inst_done", int'(inst_done), e.done);
          chk("illegal_inst", int'(illegal_inst), e.ill);
          chk("mem_err", int'(mem_err), e.err);
          chk("reset_seen", int'(rst), e.rstev);
          chk("IRWrite_cycles", ir_wr, e.ir_wr);
          chk("MemRead_cycles", mem_rd, e.mem_rd);
          chk("IorD_cycles", iord, e.iord);
          chk("MemWrite_cycles", mem_wr, e.mem_wr);
          chk("RegWrite_cycles", reg_wr, e.reg_wr);
          chk("RegDst", dst, e.dst);
          chk("MemtoReg", m2r, e.m2r);
          chk("PCWrite_exec", pc_wr, e.pc_wr);
          chk("PCSource", pcsrc, e.pcsrc);
          if (e.alu != -2) chk("ALU_Control", alu, e.alu);
        end
        n_txn++;
        cyc = 0; path = 0; last = -1; ir_wr = 0; reg_wr = 0; dst = -1; m2r = -1;
        mem_wr = 0; mem_rd = 0; iord = 0; pc_wr = 0; pcsrc = -1; alu = -1;
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    int sel, rs;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000, 6'b001010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_MemRead", int'(MemRead), 1);
    chk("rst_ALUSrcB", int'(ALUSrcB), 1);
    chk("rst_ALU_Control", int'(ALU_Control), 2);
    chk("rst_writes", int'({IRWrite, PCWrite, RegWrite, MemWrite}), 0);
    chk("rst_IorD_ALUSrcA", int'({IorD, ALUSrcA}), 0);
    chk("rst_pulses", int'({inst_done, illegal_inst, mem_err}), 0);
    mon_en = 1;

    run(6'b100011, 6'b000000, 1'b0, 0, 0, -1);   // lw, zero-wait
    run(6'b000000, 6'b100000, 1'b0, 0, 0, -1);   // add
    run(6'b000000, 6'b100111, 1'b0, 0, 0, -1);   // nor
    run(6'b000100, 6'b000000, 1'b1, 0, 0, -1);   // beq taken
    run(6'b000101, 6'b000000, 1'b1, 0, 0, -1);   // bne not taken
    run(6'b000010, 6'b000000, 1'b0, 0, 0, -1);   // j
    run(6'b101011, 6'b000000, 1'b0, 0, 3, -1);   // sw with 3 wait cycles
    run(6'b001000, 6'b000000, 1'b0, 7, 0, -1);   // fetch timeout
    run(6'b001000, 6'b000000, 1'b0, TMO, 0, -1); // ready on the last allowed cycle
    run(6'b111111, 6'b000000, 1'b0, 0, 0, -1);   // illegal opcode
    run(6'b000000, 6'b111111, 1'b0, 0, 0, -1);   // illegal funct
    run(6'b100011, 6'b000000, 1'b0, 1, 9, -1);   // lw read timeout
    run(6'b101011, 6'b000000, 1'b0, 0, TMO + 1, -1); // sw write timeout
    run(6'b101011, 6'b000000, 1'b0, 0, TMO, -1); // sw boundary success
    run(6'b001010, 6'b000000, 1'b0, 0, 0, -1);   // slti
    run(6'b000101, 6'b000000, 1'b0, 0, 0, -1);   // bne taken
    run(6'b000100, 6'b000000, 1'b0, 0, 0, -1);   // beq not taken
    run(6'b100011, 6'b000000, 1'b0, 0, 5, 2);    // reset during MRD
    run(6'b000010, 6'b000000, 1'b0, 0, 0, -1);   // j after reset

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 8);
      op = (sel == 8) ? 6'($urandom) : ops[sel];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
      run(op, fn, 1'($urandom), $urandom_range(0, TMO + 2), $urandom_range(0, TMO + 2), rs);
    end

    @(negedge clk);
    mem_ready = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
